// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared constants for the dual-rate frequency divider
package freq_div_pkg;
  localparam int SEL_W = 2;
  localparam int CH_M = 0;
  localparam int CH_V = 1;
endpackage

// File: rtl/fdiv_chan.sv
// fdiv_chan: one divider channel with button edge detect, rate select and 50% duty output
import freq_div_pkg::*;
module fdiv_chan #(
  parameter int HALF_BASE = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic f_o
);
  logic b_q, bp_q, f_q, f_d, step, term;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, half;
  always_comb begin
    step  = b_q & ~bp_q;
    half  = CNT_W'(HALF_BASE) << sel_q;
    term  = cnt_q == half - CNT_W'(1);
    sel_d = step ? sel_q + SEL_W'(1) : sel_q;
    cnt_d = (step || term) ? '0 : cnt_q + CNT_W'(1);
    f_d   = term ? ~f_q : f_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      b_q   <= 1'b0;
      bp_q  <= 1'b0;
      sel_q <= '0;
      cnt_q <= '0;
      f_q   <= 1'b0;
    end else begin
      b_q   <= btn_i;
      bp_q  <= b_q;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      f_q   <= f_d;
    end
  assign f_o = f_q;
endmodule

// File: rtl/freq_div.sv
// freq_div: two independent button-programmable clock dividers (machine and video rates)
import freq_div_pkg::*;
module freq_div #(
  parameter int M_HALF_BASE = 2,
  parameter int V_HALF_BASE = 2,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] button,
  output logic       m_f,
  output logic       v_f
);
  fdiv_chan #(.HALF_BASE(M_HALF_BASE), .CNT_W(CNT_W)) u_m (
    .clk(clk), .rst(rst), .btn_i(button[CH_M]), .f_o(m_f)
  );
  fdiv_chan #(.HALF_BASE(V_HALF_BASE), .CNT_W(CNT_W)) u_v (
    .clk(clk), .rst(rst), .btn_i(button[CH_V]), .f_o(v_f)
  );
endmodule

// File: tb/tb_freq_div.sv
// tb_freq_div: directed checks of half-periods, button stepping and async reset
module tb_freq_div;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] button = 2'b00;
  logic m_f, v_f, m_prev, v_prev;
  int total = 0, bad = 0, cyc = 0, k, t0;
  int m_last, v_last, m_hp, v_hp, m_tog, v_tog, m_first, v_first;
  int hp_seq[4] = '{4, 8, 16, 2};
  freq_div dut (.clk(clk), .rst(rst), .button(button), .m_f(m_f), .v_f(v_f));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // toggle monitor: half-period = posedges between consecutive output changes
  always @(negedge clk)
    if (rst) begin
      m_prev = 0; v_prev = 0; m_tog = 0; v_tog = 0; m_hp = 0; v_hp = 0;
      m_last = cyc; v_last = cyc; m_first = 0; v_first = 0;
    end else begin
      if (m_f !== m_prev) begin
        m_hp = cyc - m_last; m_last = cyc; m_prev = m_f; m_tog++;
        if (m_tog == 1) m_first = m_hp;
      end
      if (v_f !== v_prev) begin
        v_hp = cyc - v_last; v_last = cyc; v_prev = v_f; v_tog++;
        if (v_tog == 1) v_first = v_hp;
      end
    end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic press(input int i);
    @(negedge clk); #2 button[i] = 1'b1;
    @(negedge clk); #2 button[i] = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m", int'(m_f), 0);
    chk("rst_v", int'(v_f), 0);
    @(negedge clk); #2 rst = 1'b0;
    idle(20);
    chk("first_m", m_first, 2);
    chk("first_v", v_first, 2);
    chk("tog_m", m_tog, 10);
    chk("tog_v", v_tog, 10);
    chk("idle_hp_m", m_hp, 2);
    chk("idle_hp_v", v_hp, 2);
    press(0);
    k = cyc;
    idle(1);
    t0 = m_tog;
    for (int n = 0; n < 40 && m_tog == t0; n++) idle(1);
    chk("step_lat_m", cyc - (k + 1), 4);
    idle(250);
    chk("m_sel1", m_hp, 4);
    chk("m_sel1_v", v_hp, 2);
    for (int i = 1; i < 4; i++) begin
      press(0);
      idle(250);
      chk($sformatf("m_seq%0d", i), m_hp, hp_seq[i]);
      chk($sformatf("m_seq%0d_v", i), v_hp, 2);
    end
    for (int i = 0; i < 4; i++) begin
      press(1);
      idle(250);
      chk($sformatf("v_seq%0d", i), v_hp, hp_seq[i]);
      chk($sformatf("v_seq%0d_m", i), m_hp, 2);
    end
    @(negedge clk); #2 button = 2'b11;
    idle(100);
    chk("hold_m", m_hp, 4);
    chk("hold_v", v_hp, 4);
    button = 2'b00;
    press(0);
    idle(250);
    chk("after_hold_m", m_hp, 8);
    chk("after_hold_v", v_hp, 4);
    for (int n = 0; n < 40 && m_f !== 1'b1; n++) idle(1);
    chk("pre_rst_m_high", int'(m_f), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_m", int'(m_f), 0);
    chk("async_rst_v", int'(v_f), 0);
    idle(3);
    @(negedge clk); #2 rst = 1'b0;
    idle(30);
    chk("post_rst_first_m", m_first, 2);
    chk("post_rst_hp_m", m_hp, 2);
    chk("post_rst_hp_v", v_hp, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
